// File: rtl/calc_pkg.sv
// calc_pkg: shared op codes, ASCII command bytes and 7-segment glyphs for the calculator front end
package calc_pkg;
  localparam logic [1:0] OP_SQRT = 2'd0, OP_SIN = 2'd1, OP_COS = 2'd2, OP_PRIME = 2'd3;
  localparam logic [7:0] ASC_SPACE = 8'h20, ASC_ESC = 8'h1B, ASC_0 = 8'h30, ASC_9 = 8'h39;
  localparam logic [7:0] ASC_Q = 8'h51, ASC_B = 8'h42, ASC_C = 8'h43, ASC_P = 8'h50;
  localparam logic [3:0] CODE_MINUS = 4'd10;
  localparam logic [6:0] SEG_MINUS = 7'b1111110, SEG_BLANK = 7'b1111111;
  localparam logic [9:0][6:0] SEG_GLYPH = {7'b0000100, 7'b0000000, 7'b0001111, 7'b0100000, 7'b0100100,
                                           7'b1001100, 7'b0000110, 7'b0010010, 7'b1001111, 7'b0000001};
  // Clearing bit 5 folds lower-case letters onto upper-case
  function automatic logic is_cmd(input logic [7:0] b);
    logic [7:0] u;
    u = b & 8'hDF;
    return u == ASC_Q || u == ASC_B || u == ASC_C || u == ASC_P;
  endfunction
  function automatic logic [1:0] cmd_code(input logic [7:0] b);
    logic [7:0] u;
    u = b & 8'hDF;
    return u == ASC_B ? OP_SIN : u == ASC_C ? OP_COS : u == ASC_P ? OP_PRIME : OP_SQRT;
  endfunction
  function automatic logic [6:0] seg_of(input logic [3:0] c);
    return c < 4'd10 ? SEG_GLYPH[c] : c == CODE_MINUS ? SEG_MINUS : SEG_BLANK;
  endfunction
endpackage

// File: rtl/seg_scan.sv
// seg_scan: multiplexed 7-segment driver with scan prescaler, digit index, glyph decode and decimal point
module seg_scan
  import calc_pkg::*;
#(
  parameter int DIGITS  = 4,
  parameter int CLK_HZ  = 100_000_000,
  parameter int SCAN_HZ = 1000,
  parameter int DP_POS  = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [4*DIGITS-1:0]   bcd,
  input  logic                  neg,
  input  logic                  err,
  input  logic                  dp_en,
  output logic [DIGITS-1:0]     anode,
  output logic [6:0]            seg,
  output logic                  dp
);
  localparam int DIV = CLK_HZ / SCAN_HZ > 1 ? CLK_HZ / SCAN_HZ : 1;
  localparam int PW = $clog2(DIV + 1);
  localparam int IW = $clog2(DIGITS);
  logic [PW-1:0] pre;
  logic [IW-1:0] idx;
  logic [3:0] code;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      pre <= '0;
      idx <= '0;
    end else if (pre == PW'(DIV - 1)) begin
      pre <= '0;
      idx <= idx == IW'(DIGITS - 1) ? '0 : idx + 1'b1;
    end else
      pre <= pre + 1'b1;
  // Digit 0 is the MSD, so it sits in the top nibble and drives the top anode bit
  always_comb begin
    code  = err || (idx == '0 && neg) ? CODE_MINUS : bcd[4*(DIGITS-1-int'(idx)) +: 4];
    seg   = seg_of(code);
    dp    = !(dp_en && idx == IW'(DP_POS));
    anode = ~(DIGITS'(1) << (DIGITS - 1 - int'(idx)));
  end
endmodule

// File: rtl/calc_cmd_display.sv
// calc_cmd_display: ASCII command parser that issues compute requests and shows the latched result
module calc_cmd_display
  import calc_pkg::*;
#(
  parameter int CLK_HZ  = 100_000_000,
  parameter int DIGITS  = 4,
  parameter int OP_W    = 9,
  parameter int SCAN_HZ = 1000,
  parameter int DP_POS  = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [7:0]          rx_data,
  input  logic                rx_valid,
  output logic [OP_W-1:0]     op_value,
  output logic [1:0]          op_code,
  output logic                op_req,
  input  logic                op_ack,
  input  logic [4*DIGITS-1:0] res_bcd,
  input  logic                res_neg,
  output logic [DIGITS-1:0]   anode,
  output logic [6:0]          seg,
  output logic                dp,
  output logic                busy,
  output logic                err
);
  localparam logic [1:0] IDLE = 2'd0, ENTRY = 2'd1, READY = 2'd2, REQ = 2'd3;
  localparam logic [OP_W-1:0] MAXV = '1;
  logic [1:0] state;
  logic [OP_W-1:0] acc;
  logic [OP_W+3:0] nxt;
  logic ovf, is_dig;
  logic [4*DIGITS-1:0] disp_bcd;
  logic disp_neg;
  logic [1:0] disp_code;
  always_comb begin
    is_dig = rx_data >= ASC_0 && rx_data <= ASC_9;
    nxt    = (OP_W+4)'(acc) * (OP_W+4)'(10) + (OP_W+4)'(rx_data[3:0]);
    ovf    = nxt > (OP_W+4)'(MAXV);
  end
  assign busy = state == REQ;
  // ESC outranks a coinciding ack; other bytes arriving in REQ are dropped
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state     <= IDLE;
      acc       <= '0;
      op_value  <= '0;
      op_code   <= OP_SQRT;
      op_req    <= 1'b0;
      err       <= 1'b0;
      disp_bcd  <= '0;
      disp_neg  <= 1'b0;
      disp_code <= OP_SQRT;
    end else if (rx_valid && rx_data == ASC_ESC) begin
      state     <= IDLE;
      acc       <= '0;
      err       <= 1'b0;
      op_req    <= 1'b0;
      disp_bcd  <= '0;
      disp_neg  <= 1'b0;
      disp_code <= OP_SQRT;
    end else if (state == REQ) begin
      if (op_ack) begin
        disp_bcd  <= res_bcd;
        disp_neg  <= res_neg;
        disp_code <= op_code;
        op_req    <= 1'b0;
        state     <= READY;
      end
    end else if (rx_valid) begin
      if (is_dig) begin
        acc   <= ovf ? MAXV : nxt[OP_W-1:0];
        err   <= ovf;
        state <= ENTRY;
      end else if (rx_data == ASC_SPACE && state == ENTRY) begin
        if (!err) op_value <= acc;
        acc   <= '0;
        err   <= 1'b0;
        state <= err ? IDLE : READY;
      end else if (is_cmd(rx_data)) begin
        if (state == READY) begin
          op_code <= cmd_code(rx_data);
          op_req  <= 1'b1;
          state   <= REQ;
        end else
          err <= 1'b1;
      end
    end
  seg_scan #(.DIGITS(DIGITS), .CLK_HZ(CLK_HZ), .SCAN_HZ(SCAN_HZ), .DP_POS(DP_POS)) u_scan (
    .clk   (clk),
    .reset (reset),
    .bcd   (disp_bcd),
    .neg   (disp_neg),
    .err   (err),
    .dp_en (disp_code == OP_SIN || disp_code == OP_COS),
    .anode (anode),
    .seg   (seg),
    .dp    (dp)
  );
endmodule

// File: tb/tb_calc_cmd_display.sv
// tb_calc_cmd_display: directed and random byte streams checked against a behavioural parser/display model
module tb_calc_cmd_display;
  localparam int DIGITS = 4, OP_W = 9, DP_POS = 1, MAXV = (1 << OP_W) - 1;
  logic clk = 0, reset = 1, rx_valid = 0, op_ack = 0, res_neg = 0;
  logic [7:0] rx_data = 0;
  logic [15:0] res_bcd = 0;
  logic [OP_W-1:0] op_value;
  logic [1:0] op_code;
  logic op_req, busy, err, dp;
  logic [3:0] anode;
  logic [6:0] seg;
  int checks = 0, failures = 0;
  int m_acc, m_opv, m_code, m_dbcd, m_dcode;
  bit m_err, m_req, m_typing, m_armed, m_dneg;
  logic [7:0] cmds [8] = '{"Q", "q", "B", "b", "C", "c", "P", "p"};
  logic [7:0] junk [4] = '{8'h41, 8'h00, 8'h0A, 8'h7F};

  always #5 clk = ~clk;

  calc_cmd_display #(.CLK_HZ(4000), .DIGITS(DIGITS), .OP_W(OP_W), .SCAN_HZ(1000), .DP_POS(DP_POS)) dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid), .op_value(op_value),
    .op_code(op_code), .op_req(op_req), .op_ack(op_ack), .res_bcd(res_bcd), .res_neg(res_neg),
    .anode(anode), .seg(seg), .dp(dp), .busy(busy), .err(err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic void m_clear();
    {m_acc, m_opv, m_code, m_dbcd, m_dcode} = '0;
    {m_err, m_req, m_typing, m_armed, m_dneg} = '0;
  endfunction

  function automatic void m_step(input bit v, input logic [7:0] b, input bit a);
    int n, c;
    if (v && b == 8'h1B) begin
      {m_acc, m_err, m_req, m_typing, m_armed, m_dbcd, m_dneg, m_dcode} = '0;
      return;
    end
    if (m_req) begin
      if (a) begin
        m_dbcd = res_bcd; m_dneg = res_neg; m_dcode = m_code; m_req = 0;
      end
      return;
    end
    if (!v) return;
    case (b)
      "Q", "q": c = 0;
      "B", "b": c = 1;
      "C", "c": c = 2;
      "P", "p": c = 3;
      default:  c = -1;
    endcase
    if (b >= "0" && b <= "9") begin
      n = m_acc * 10 + int'(b - "0");
      m_err = n > MAXV;
      m_acc = m_err ? MAXV : n;
      m_typing = 1; m_armed = 0;
    end else if (b == " " && m_typing) begin
      if (!m_err) begin m_opv = m_acc; m_armed = 1; end
      m_acc = 0; m_err = 0; m_typing = 0;
    end else if (c >= 0) begin
      if (m_armed) begin m_code = c; m_req = 1; end
      else m_err = 1;
    end
  endfunction

  function automatic logic [6:0] glyph(input int c);
    case (c)
      0: return 7'b0000001; 1: return 7'b1001111; 2: return 7'b0010010; 3: return 7'b0000110;
      4: return 7'b1001100; 5: return 7'b0100100; 6: return 7'b0100000; 7: return 7'b0001111;
      8: return 7'b0000000; 9: return 7'b0000100; 10: return 7'b1111110;
      default: return 7'b1111111;
    endcase
  endfunction

  function automatic logic [6:0] exp_seg(input int i);
    return glyph(m_err || (i == 0 && m_dneg) ? 10 : (m_dbcd >> (4 * (DIGITS - 1 - i))) & 15);
  endfunction

  task automatic check_outputs(input string tag);
    check({tag, ":op_req"}, op_req, m_req);
    check({tag, ":busy"}, busy, m_req);
    check({tag, ":err"}, err, m_err);
    check({tag, ":op_value"}, op_value, m_opv);
    check({tag, ":op_code"}, op_code, m_code);
  endtask

  task automatic tx(input bit v, input logic [7:0] b, input bit a);
    @(negedge clk);
    rx_valid = v; rx_data = b; op_ack = a;
    @(negedge clk);
    rx_valid = 0; op_ack = 0;
    m_step(v, b, a);
    check_outputs($sformatf("byte%02h_v%0d_a%0d", b, v, a));
  endtask

  task automatic send(input string s);
    for (int i = 0; i < s.len(); i++) tx(1, s[i], 0);
  endtask

  task automatic ack(input logic [15:0] bcd, input bit neg);
    res_bcd = bcd; res_neg = neg;
    tx(0, 8'h00, 1);
  endtask

  task automatic show(input string tag);
    logic [6:0] sg [DIGITS];
    logic dv [DIGITS];
    bit [DIGITS-1:0] seen = '0;
    bit bad = 0;
    int idx;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      idx = -1;
      for (int i = 0; i < DIGITS; i++) if (anode == ~(4'b1000 >> i)) idx = i;
      if (idx < 0) bad = 1;
      else if (!seen[idx]) begin seen[idx] = 1; sg[idx] = seg; dv[idx] = dp; end
    end
    check({tag, ":anode_onehot"}, bad, 0);
    for (int i = 0; i < DIGITS; i++) begin
      check($sformatf("%s:seen%0d", tag, i), seen[i], 1);
      if (seen[i]) begin
        check($sformatf("%s:seg%0d", tag, i), sg[i], exp_seg(i));
        check($sformatf("%s:dp%0d", tag, i), dv[i], !((m_dcode == 1 || m_dcode == 2) && i == DP_POS));
      end
    end
  endtask

  initial begin
    int r;
    logic [7:0] b;
    m_clear();
    repeat (2) @(negedge clk);
    check_outputs("in_reset");
    check("in_reset:anode", anode, 4'b0111);
    check("in_reset:seg", seg, 7'b0000001);
    check("in_reset:dp", dp, 1);
    reset = 0;
    #1 check("post_reset:anode", anode, 4'b0111);
    show("after_reset");

    send("49 Q");
    repeat (3) tx(0, 8'h00, 0);
    ack(16'h0007, 0);
    show("sqrt49");

    send("30 B");
    ack(16'h0500, 0);
    show("sin30");

    send("180 C");
    ack(16'h1000, 1);
    show("cos180");

    send("600");
    show("overflow");
    send(" ");
    show("overflow_space");

    send("Q");
    tx(0, 8'h00, 0);
    send("12 P");
    tx(1, 8'h1B, 0);
    show("esc_in_req");

    send("7 Q");
    res_bcd = 16'h0042; res_neg = 0;
    tx(1, "3", 1);
    show("digit_with_ack");
    send("5 ");

    send("Q");
    res_bcd = 16'h0099;
    tx(1, 8'h1B, 1);
    show("esc_with_ack");

    send("8 P");
    @(negedge clk);
    #2 reset = 1;
    #1 check("async_reset:op_req", op_req, 0);
    check("async_reset:busy", busy, 0);
    @(negedge clk);
    reset = 0;
    m_clear();
    #1 check("async_reset:anode", anode, 4'b0111);
    check_outputs("async_reset");

    for (int it = 0; it < 400; it++) begin
      r = $urandom_range(0, 99);
      b = r < 50 ? 8'h30 + 8'($urandom_range(0, 9)) : r < 65 ? 8'h20 : r < 85 ? cmds[$urandom_range(0, 7)] :
          r < 88 ? 8'h1B : junk[$urandom_range(0, 3)];
      for (int k = 0; k < 4; k++) res_bcd[4*k +: 4] = 4'($urandom_range(0, 15) < 13 ? $urandom_range(0, 9) : $urandom_range(10, 15));
      res_neg = 1'($urandom_range(0, 1));
      tx($urandom_range(0, 19) != 0, b, $urandom_range(0, 3) == 0);
      if (it % 25 == 24) show($sformatf("rand%0d", it));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
